menu_config_ctrl: RTL and testbench

//  Sequences the game configuration menu: modo -> BPM -> tom -> musica, from keyboard arrow/enter keys.

---
 rtl/menu_pkg.sv | 43 ++++
 rtl/menu_edge_detect.sv | 29 ++
 rtl/menu_config_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_menu_config_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/menu_pkg.sv
// ============================================================================
// Module      : menu_pkg
// Description : Shared menu_sel codes and stage helpers for menu_config_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package menu_pkg;

  typedef enum logic [2:0] {
    MENU_IDLE   = 3'd0,
    MENU_MODO   = 3'd1,
    MENU_BPM    = 3'd2,
    MENU_TOM    = 3'd3,
    MENU_MUSICA = 3'd4,
    MENU_DONE   = 3'd5
  } menu_sel_e;

  // Number of options offered by the stage selected by sel; 1 outside the menu.
  function automatic int unsigned stage_size(
    input logic [2:0]  sel,
    input int unsigned n_modo,
    input int unsigned n_bpm,
    input int unsigned n_tom,
    input int unsigned n_musica
  );
    case (sel)
      MENU_MODO:   stage_size = n_modo;
      MENU_BPM:    stage_size = n_bpm;
      MENU_TOM:    stage_size = n_tom;
      MENU_MUSICA: stage_size = n_musica;
      default:     stage_size = 1;
    endcase
  endfunction

  function automatic logic is_menu_stage(input logic [2:0] sel);
    is_menu_stage = (sel == MENU_MODO) || (sel == MENU_BPM) ||
                    (sel == MENU_TOM)  || (sel == MENU_MUSICA);
  endfunction

endpackage

`default_nettype wire

// File: rtl/menu_edge_detect.sv
// ============================================================================
// Module      : menu_edge_detect
// Description : 1-bit rising-edge detector with synchronous active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module menu_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic i_level,
  output logic o_rise
);

  logic level_q;
  logic level_d;

  always_comb level_d = i_level;

  always_ff @(posedge clock) begin
    if (reset) level_q <= 1'b0;
    else       level_q <= level_d;
  end

  assign o_rise = i_level & ~level_q;

endmodule

`default_nettype wire

// File: rtl/menu_config_ctrl.sv
// ============================================================================
// Module      : menu_config_ctrl
// Description : Configuration menu sequencer (modo -> BPM -> tom -> musica).
//               Optional idle auto-commit enabled by defining MENU_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module menu_config_ctrl
  import menu_pkg::*;
#(
  parameter int unsigned MODO       = 6,
  parameter int unsigned BPM        = 2,
  parameter int unsigned TOM        = 4,
  parameter int unsigned MUSICA     = 16,
  parameter int unsigned MODO_LIVRE = 5,
  parameter int unsigned TIMEOUT    = 250_000_000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      inicia_menu,
  input  logic                      right_arrow_pressed,
  input  logic                      left_arrow_pressed,
  input  logic                      enter_pressed,
  output logic [2:0]                menu_sel,
  output logic [$clog2(MUSICA)-1:0] opcao,
  output logic                      registra_modo,
  output logic                      registra_bpm,
  output logic                      registra_tom,
  output logic                      registra_musicas,
  output logic                      mostra_menu,
  output logic                      menu_done
);

  localparam int unsigned   OW        = $clog2(MUSICA);
  localparam logic [OW-1:0] LIVRE_IDX = OW'(MODO_LIVRE);

  logic right_ev, left_ev, enter_ev;
  logic timeout_hit, take_enter, confirm, strobe_any;

  menu_sel_e     state_q, state_d;
  logic [OW-1:0] cursor_q, cursor_d;
  logic [OW-1:0] modo_conf_q, modo_conf_d;
  logic [OW-1:0] last_idx;
  logic          reg_modo_q, reg_modo_d;
  logic          reg_bpm_q, reg_bpm_d;
  logic          reg_tom_q, reg_tom_d;
  logic          reg_mus_q, reg_mus_d;
  logic          mostra_q, mostra_d;
  logic          done_q, done_d;

  menu_edge_detect u_edge_right (
    .clock   (clock),
    .reset   (reset),
    .i_level (right_arrow_pressed),
    .o_rise  (right_ev)
  );

  menu_edge_detect u_edge_left (
    .clock   (clock),
    .reset   (reset),
    .i_level (left_arrow_pressed),
    .o_rise  (left_ev)
  );

  menu_edge_detect u_edge_enter (
    .clock   (clock),
    .reset   (reset),
    .i_level (enter_pressed),
    .o_rise  (enter_ev)
  );

  assign strobe_any = reg_modo_q | reg_bpm_q | reg_tom_q | reg_mus_q;
  assign last_idx   = OW'(stage_size(state_q, MODO, BPM, TOM, MUSICA) - 1);
  // Keys are not acted on in the strobe cycle, while the cursor is being cleared.
  assign take_enter = !strobe_any && (enter_ev || timeout_hit);

`ifdef MENU_TIMEOUT_EN
  logic [27:0] idle_cnt_q, idle_cnt_d;

  always_comb begin
    idle_cnt_d = idle_cnt_q + 28'd1;
    if (!is_menu_stage(state_q) || strobe_any || right_ev || left_ev ||
        enter_ev || (state_d != state_q))
      idle_cnt_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) idle_cnt_q <= '0;
    else       idle_cnt_q <= idle_cnt_d;
  end

  assign timeout_hit = is_menu_stage(state_q) && (idle_cnt_q == 28'(TIMEOUT - 1));
`else
  logic timeout_unused;
  assign timeout_unused = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= MENU_IDLE;
      cursor_q    <= '0;
      modo_conf_q <= '0;
      reg_modo_q  <= 1'b0;
      reg_bpm_q   <= 1'b0;
      reg_tom_q   <= 1'b0;
      reg_mus_q   <= 1'b0;
      mostra_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      modo_conf_q <= modo_conf_d;
      reg_modo_q  <= reg_modo_d;
      reg_bpm_q   <= reg_bpm_d;
      reg_tom_q   <= reg_tom_d;
      reg_mus_q   <= reg_mus_d;
      mostra_q    <= mostra_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    confirm = 1'b0;
    case (state_q)
      MENU_IDLE, MENU_DONE: if (inicia_menu) state_d = MENU_MODO;
      MENU_MODO: if (take_enter) begin
        confirm = 1'b1;
        state_d = MENU_BPM;
      end
      MENU_BPM: if (take_enter) begin
        confirm = 1'b1;
        state_d = MENU_TOM;
      end
      MENU_TOM: if (take_enter) begin
        confirm = 1'b1;
        state_d = (modo_conf_q == LIVRE_IDX) ? MENU_DONE : MENU_MUSICA;
      end
      MENU_MUSICA: if (take_enter) begin
        confirm = 1'b1;
        state_d = MENU_DONE;
      end
      default: state_d = MENU_IDLE;
    endcase
  end

  always_comb begin
    cursor_d    = cursor_q;
    modo_conf_d = modo_conf_q;
    reg_modo_d  = 1'b0;
    reg_bpm_d   = 1'b0;
    reg_tom_d   = 1'b0;
    reg_mus_d   = 1'b0;
    mostra_d    = is_menu_stage(state_d);
    done_d      = (state_d == MENU_DONE) && (state_q != MENU_DONE);
    if (strobe_any) begin
      cursor_d = '0;
    end else if (confirm) begin
      case (state_q)
        MENU_MODO: begin
          reg_modo_d  = 1'b1;
          modo_conf_d = cursor_q;
        end
        MENU_BPM:    reg_bpm_d = 1'b1;
        MENU_TOM:    reg_tom_d = 1'b1;
        MENU_MUSICA: reg_mus_d = 1'b1;
        default:     ;
      endcase
    end else if (is_menu_stage(state_q) && (right_ev ^ left_ev)) begin
      if (right_ev) cursor_d = (cursor_q == last_idx) ? '0 : cursor_q + 1'b1;
      else          cursor_d = (cursor_q == '0) ? last_idx : cursor_q - 1'b1;
    end
  end

  assign menu_sel         = state_q;
  assign opcao            = cursor_q;
  assign registra_modo    = reg_modo_q;
  assign registra_bpm     = reg_bpm_q;
  assign registra_tom     = reg_tom_q;
  assign registra_musicas = reg_mus_q;
  assign mostra_menu      = mostra_q;
  assign menu_done        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_menu_config_ctrl.sv
// ============================================================================
// Module      : tb_menu_config_ctrl
// Description : Scoreboard bench for menu_config_ctrl against a stage/cursor model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_menu_config_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       inicia_menu = 1'b0;
  logic       right_arrow_pressed = 1'b0;
  logic       left_arrow_pressed = 1'b0;
  logic       enter_pressed = 1'b0;
  logic [2:0] menu_sel;
  logic [3:0] opcao;
  logic       registra_modo, registra_bpm, registra_tom, registra_musicas;
  logic       mostra_menu, menu_done;

  menu_config_ctrl dut (
    .clock               (clock),
    .reset               (reset),
    .inicia_menu         (inicia_menu),
    .right_arrow_pressed (right_arrow_pressed),
    .left_arrow_pressed  (left_arrow_pressed),
    .enter_pressed       (enter_pressed),
    .menu_sel            (menu_sel),
    .opcao               (opcao),
    .registra_modo       (registra_modo),
    .registra_bpm        (registra_bpm),
    .registra_tom        (registra_tom),
    .registra_musicas    (registra_musicas),
    .mostra_menu         (mostra_menu),
    .menu_done           (menu_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    int kind;  // 1..4 = registra_* of that stage, 5 = menu_done
    int val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: stage number equals the menu_sel code.
  int stage  = 0;
  int cur    = 0;
  int modo_c = 0;

  function automatic int n_of(input int s);
    case (s)
      1: return 6;
      2: return 2;
      3: return 4;
      4: return 16;
      default: return 1;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_arrow(input int dir);
    if (stage >= 1 && stage <= 4) cur = (cur + dir + n_of(stage)) % n_of(stage);
  endtask

  task automatic model_enter();
    exp_t e;
    if (stage >= 1 && stage <= 4) begin
      e.kind = stage;
      e.val  = cur;
      exp_q.push_back(e);
      if (stage == 1) modo_c = cur;
      if (stage == 4 || (stage == 3 && modo_c == 5)) begin
        stage  = 5;
        e.kind = 5;
        e.val  = 0;
        exp_q.push_back(e);
      end else begin
        stage++;
      end
      cur = 0;
    end
  endtask

  task automatic model_inicia();
    if (stage == 0 || stage == 5) begin
      stage = 1;
      cur   = 0;
    end
  endtask

  task automatic sb_pop(input int kind);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_strobe: got kind %0d opcao %0d, expected none", kind, opcao);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind < 5 && e.val != int'(opcao))) begin
        errors++;
        $display("FAIL strobe: got kind %0d opcao %0d expected kind %0d opcao %0d",
                 kind, opcao, e.kind, e.val);
      end
    end
  endtask

  // Monitor: every strobe or done pulse the DUT presents is matched against the queue.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (registra_modo)    sb_pop(1);
        if (registra_bpm)     sb_pop(2);
        if (registra_tom)     sb_pop(3);
        if (registra_musicas) sb_pop(4);
        if (menu_done)        sb_pop(5);
      end
    end
  end

  task automatic act(input bit r, input bit l, input bit e, input bit i, input int hold);
    @(negedge clock);
    right_arrow_pressed = r;
    left_arrow_pressed  = l;
    enter_pressed       = e;
    inicia_menu         = i;
    repeat (hold) @(negedge clock);
    right_arrow_pressed = 1'b0;
    left_arrow_pressed  = 1'b0;
    enter_pressed       = 1'b0;
    inicia_menu         = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_menu_sel"}, int'(menu_sel), stage);
    chk({tag, "_opcao"}, int'(opcao), cur);
    chk({tag, "_mostra"}, int'(mostra_menu), (stage >= 1 && stage <= 4) ? 1 : 0);
  endtask

  task automatic right(input int hold);
    model_arrow(1);
    act(1, 0, 0, 0, hold);
  endtask

  task automatic left();
    model_arrow(-1);
    act(0, 1, 0, 0, 1);
  endtask

  task automatic enter();
    model_enter();
    act(0, 0, 1, 0, 1);
  endtask

  task automatic inicia();
    model_inicia();
    act(0, 0, 0, 1, 1);
  endtask

  // Enter with exact latency checks: strobe in the next cycle only, cursor cleared after.
  task automatic enter_timed(input bit with_right);
    @(negedge clock);
    enter_pressed       = 1'b1;
    right_arrow_pressed = with_right;
    model_enter();
    @(negedge clock);
    enter_pressed       = 1'b0;
    right_arrow_pressed = 1'b0;
    chk("strobe_latency", int'(registra_modo | registra_bpm | registra_tom | registra_musicas), 1);
    chk("sel_advance", int'(menu_sel), stage);
    @(negedge clock);
    chk("strobe_width", int'(registra_modo | registra_bpm | registra_tom | registra_musicas | menu_done), 0);
    chk("cursor_clear", int'(opcao), 0);
    repeat (2) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_menu_sel", int'(menu_sel), 0);
    chk("rst_opcao", int'(opcao), 0);
    chk("rst_strobes", int'({registra_modo, registra_bpm, registra_tom, registra_musicas, menu_done}), 0);
    chk("rst_mostra", int'(mostra_menu), 0);
    reset = 1'b0;
    stage = 0;
    cur   = 0;
    modo_c = 0;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clock);
    chk("init_menu_sel", int'(menu_sel), 0);
    chk("init_opcao", int'(opcao), 0);
    chk("init_mostra", int'(mostra_menu), 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    inicia();
    check_state("start");
    right(1);
    right(1);
    check_state("modo_r2");
    enter_timed(1'b0);
    inicia();
    check_state("inicia_ignored");
    enter_timed(1'b1);
    left();
    check_state("tom_wrap");
    enter();
    check_state("to_musica");
    for (int i = 0; i < 16; i++) right(1);
    check_state("musica_wrap");
    right(100);
    check_state("held_right");
    act(1, 1, 0, 0, 1);
    check_state("both_arrows");
    enter();
    check_state("done");
    right(1);
    check_state("done_keys_ignored");

    inicia();
    for (int i = 0; i < 5; i++) right(1);
    enter();
    enter();
    enter_timed(1'b0);
    check_state("livre_skip");

    inicia();
    enter();
    enter();
    right(1);
    check_state("pre_reset_tom");
    do_reset();
    check_state("post_reset");

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 6))
        0, 1: right(1 + $urandom_range(0, 3));
        2:    left();
        3:    enter();
        4:    act(1, 1, 0, 0, 1);
        5: begin
          model_enter();
          act(1, 0, 1, 0, 1);
        end
        default: inicia();
      endcase
      if (n % 10 == 0) check_state("rand");
    end

    repeat (4) @(negedge clock);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
